// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter sharing one unsigned eq/gt/lt comparator between N_REQ requesters,
// returning a registered, id-tagged result over a valid/ready response channel.
module cmp_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4,
  parameter int CNT_W = 8,
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic                   rsp_eq,
  output logic                   rsp_gt,
  output logic                   rsp_lt,
  output logic [CNT_W-1:0]       cmp_count
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  // Result bundle ordered {eq, gt, lt}; exactly one bit is set for any operand pair.
  function automatic logic [2:0] cmp_fn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    cmp_fn = {(a == b), (a > b), (a < b)};
  endfunction

  logic [0:0]       state_r;
  logic [IDW-1:0]   ptr_r;
  logic [IDW-1:0]   id_r;
  logic [2:0]       res_r;
  logic [CNT_W-1:0] count_r;

  logic             can_accept_s;
  logic             found_s;
  logic [IDW-1:0]   grant_id_s;
  logic [N_REQ-1:0] grant_s;
  logic             accept_s;
  logic             rsp_hs_s;
  logic [WIDTH-1:0] a_sel_s;
  logic [WIDTH-1:0] b_sel_s;
  logic [IDW-1:0]   ptr_next_s;

  assign can_accept_s = (state_r == ST_EMPTY) | rsp_ready;
  assign rsp_hs_s     = (state_r == ST_FULL) & rsp_ready;
  assign accept_s     = |grant_s;

  // Find the first valid requester at or after the pointer and issue a one-hot grant.
  always_comb begin
    found_s    = 1'b0;
    grant_id_s = '0;
    grant_s    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = (int'(ptr_r) + k) % N_REQ;
      if (!found_s && req_valid[idx]) begin
        found_s    = 1'b1;
        grant_id_s = IDW'(idx);
      end else begin
        found_s    = found_s;
      end
    end
    if (found_s && can_accept_s && !rst) begin
      grant_s[grant_id_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  // Operand mux and next round-robin pointer for the granted requester.
  always_comb begin
    a_sel_s = req_a[int'(grant_id_s)*WIDTH +: WIDTH];
    b_sel_s = req_b[int'(grant_id_s)*WIDTH +: WIDTH];
    if (int'(grant_id_s) == N_REQ - 1) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = grant_id_s + IDW'(1);
    end
  end

  // Response slot: a new accept reloads it even while the old result is being consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_EMPTY;
      ptr_r   <= '0;
      id_r    <= '0;
      res_r   <= 3'b000;
      count_r <= '0;
    end else begin
      if (accept_s) begin
        state_r <= ST_FULL;
        id_r    <= grant_id_s;
        res_r   <= cmp_fn(a_sel_s, b_sel_s);
        ptr_r   <= ptr_next_s;
      end else if (rsp_hs_s) begin
        state_r <= ST_EMPTY;
      end
      if (rsp_hs_s) begin
        count_r <= count_r + CNT_W'(1);
      end
    end
  end

  assign req_ready = grant_s;
  assign rsp_valid = (state_r == ST_FULL);
  assign rsp_id    = id_r;
  assign rsp_eq    = res_r[2];
  assign rsp_gt    = res_r[1];
  assign rsp_lt    = res_r[0];
  assign cmp_count = count_r;

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Directed bench for cmp_share_arbiter: arbitration order, backpressure, fairness,
// mid-operation reset and completed-compare counter wrap.
module tb_cmp_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic        rsp_eq;
  logic        rsp_gt;
  logic        rsp_lt;
  logic [7:0]  cmp_count;

  int checks = 0;
  int failures = 0;

  cmp_share_arbiter #(.N_REQ(4), .WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_eq(rsp_eq), .rsp_gt(rsp_gt), .rsp_lt(rsp_lt),
    .cmp_count(cmp_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rsp(input string tag, input logic [1:0] id, input logic [2:0] egl);
    chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, "_id"}, {30'd0, rsp_id}, {30'd0, id});
    chk({tag, "_egl"}, {29'd0, rsp_eq, rsp_gt, rsp_lt}, {29'd0, egl});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  logic [3:0] fair_exp [4];
  logic [1:0] fair_id [4];

  initial begin
    rst = 1'b1;
    req_valid = 4'b1111;
    rsp_ready = 1'b0;
    req_a = 16'h0000;
    req_b = 16'h0000;
    #2;
    chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_id", {30'd0, rsp_id}, 32'd0);
    chk("rst_egl", {29'd0, rsp_eq, rsp_gt, rsp_lt}, 32'd0);
    chk("rst_count", {24'd0, cmp_count}, 32'd0);
    req_valid = 4'b0000;
    step();
    rst = 1'b0;
    #1;

    // Single request, equal operands
    req_valid = 4'b0001;
    req_a = 16'h0005;
    req_b = 16'h0005;
    #1;
    chk("t1_req_ready", {28'd0, req_ready}, 32'h1);
    step();
    req_valid = 4'b0000;
    chk_rsp("t1_rsp", 2'd0, 3'b100);
    rsp_ready = 1'b1;
    step();
    chk("t1_consumed_valid", {31'd0, rsp_valid}, 32'd0);
    chk("t1_count", {24'd0, cmp_count}, 32'd1);

    // Four requesters back-to-back from pointer 0: a=12/3/15/0, b=7/9/0/15
    do_reset();
    chk("t2_count_after_rst", {24'd0, cmp_count}, 32'd0);
    rsp_ready = 1'b1;
    req_a = {4'd0, 4'd15, 4'd3, 4'd12};
    req_b = {4'd15, 4'd0, 4'd9, 4'd7};
    req_valid = 4'b1111;
    #1;
    chk("t2_grant0", {28'd0, req_ready}, 32'h1);
    step();
    req_valid = 4'b1110;
    #1;
    chk_rsp("t2_rsp0", 2'd0, 3'b010);
    chk("t2_grant1", {28'd0, req_ready}, 32'h2);
    step();
    req_valid = 4'b1100;
    #1;
    chk_rsp("t2_rsp1", 2'd1, 3'b001);
    chk("t2_grant2", {28'd0, req_ready}, 32'h4);
    step();
    req_valid = 4'b1000;
    #1;
    chk_rsp("t2_rsp2", 2'd2, 3'b010);
    chk("t2_grant3", {28'd0, req_ready}, 32'h8);
    step();
    req_valid = 4'b0000;
    chk_rsp("t2_rsp3", 2'd3, 3'b001);
    step();
    chk("t2_drained", {31'd0, rsp_valid}, 32'd0);
    chk("t2_count", {24'd0, cmp_count}, 32'd4);

    // Backpressure: hold requester 1's result (9 > 4) for five cycles
    rsp_ready = 1'b0;
    req_a = {4'd0, 4'd7, 4'd9, 4'd0};
    req_b = {4'd0, 4'd7, 4'd4, 4'd0};
    req_valid = 4'b0010;
    #1;
    chk("t3_grant1", {28'd0, req_ready}, 32'h2);
    step();
    req_valid = 4'b1111;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("t3_bp_ready", {28'd0, req_ready}, 32'd0);
      chk_rsp("t3_bp_rsp", 2'd1, 3'b010);
      step();
    end
    chk("t3_bp_count", {24'd0, cmp_count}, 32'd4);
    rsp_ready = 1'b1;
    #1;
    chk("t3_release_grant", {28'd0, req_ready}, 32'h4);
    step();
    req_valid = 4'b0000;
    chk_rsp("t3_reload", 2'd2, 3'b100);
    chk("t3_reload_count", {24'd0, cmp_count}, 32'd5);
    step();
    chk("t3_drained", {31'd0, rsp_valid}, 32'd0);
    chk("t3_count", {24'd0, cmp_count}, 32'd6);

    // Fairness between requesters 0 and 2 (pointer currently 3)
    fair_exp = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
    fair_id = '{2'd0, 2'd2, 2'd0, 2'd2};
    req_a = {4'd0, 4'd3, 4'd0, 4'd1};
    req_b = {4'd0, 4'd3, 4'd0, 4'd2};
    req_valid = 4'b0101;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("t4_grant", {28'd0, req_ready}, {28'd0, fair_exp[i]});
      step();
      chk("t4_rsp_id", {30'd0, rsp_id}, {30'd0, fair_id[i]});
    end
    chk("t4_count", {24'd0, cmp_count}, 32'd9);

    // Reset while requester 2's result is held
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    #1;
    chk_rsp("t5_held", 2'd2, 3'b100);
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("t5_rst_count", {24'd0, cmp_count}, 32'd0);
    chk("t5_rst_ready", {28'd0, req_ready}, 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("t5_next_grant", {28'd0, req_ready}, 32'h1);
    step();
    chk_rsp("t5_rsp", 2'd0, 3'b001);

    // Counter wrap: stream one handshake per cycle
    rsp_ready = 1'b1;
    for (int i = 0; i < 255; i++) begin
      step();
    end
    chk("t6_count255", {24'd0, cmp_count}, 32'd255);
    step();
    chk("t6_wrap", {24'd0, cmp_count}, 32'd0);
    chk("t6_valid", {31'd0, rsp_valid}, 32'd1);
    chk("t6_onehot", {29'd0, rsp_eq, rsp_gt, rsp_lt} == 32'd1 ||
                     {29'd0, rsp_eq, rsp_gt, rsp_lt} == 32'd2 ||
                     {29'd0, rsp_eq, rsp_gt, rsp_lt} == 32'd4, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
